// File: rtl/program_counter_pkg.sv
// program_counter_pkg: shared word width, reset address and the {clr, load, inc, dec} control encoding
package program_counter_pkg;
  localparam int WORD_WIDTH = 16;
  localparam logic [WORD_WIDTH-1:0] DEFAULT_PC_RESET = '0;
  typedef struct packed {
    logic clr;
    logic load;
    logic inc;
    logic dec;
  } pc_ctrl_t;
endpackage

// File: rtl/program_counter_if.sv
// program_counter_if: controls clr/load/inc/dec and in from jump logic (master), out/wrap back from the counter (slave)
interface program_counter_if import program_counter_pkg::*; #(parameter int WIDTH = WORD_WIDTH);
  logic clr;
  logic load;
  logic inc;
  logic dec;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic wrap;
  modport master (output clr, load, inc, dec, in, input out, wrap);
  modport slave (input clr, load, inc, dec, in, output out, wrap);
endinterface

// File: rtl/program_counter_word_register.sv
// word_register: WIDTH-bit register; clk, rst_n (async low to RESET_VAL), en loads d into q
module word_register #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RESET_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/program_counter.sv
// program_counter: clk, rst_n (async low), bus.slave; priority clr>load>inc/dec>hold, registered out and one-cycle wrap pulse
module program_counter import program_counter_pkg::*; #(
  parameter int WIDTH = WORD_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_PC_RESET)
) (
  input  logic clk,
  input  logic rst_n,
  program_counter_if.slave bus
);
  pc_ctrl_t ctrl;
  logic [WIDTH-1:0] q, d;
  logic up, down, en, wrap_d, wrap_q;
  assign ctrl = {bus.clr, bus.load, bus.inc, bus.dec};
  always_comb begin
    up = ctrl.inc && !ctrl.dec;
    down = ctrl.dec && !ctrl.inc;
    en = ctrl.clr || ctrl.load || up || down;
    d = ctrl.clr ? RESET_VAL : ctrl.load ? bus.in : up ? q + 1'b1 : down ? q - 1'b1 : q;
    wrap_d = !ctrl.clr && !ctrl.load && ((up && &q) || (down && ~|q));
  end
  word_register #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_reg (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .d(d),
    .q(q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wrap_q <= 1'b0;
    else wrap_q <= wrap_d;
  assign bus.out = q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed and random stimulus against a reference model through a scoreboard queue
module tb_program_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] m_out = 16'h0;
  logic m_wrap = 1'b0;
  logic [16:0] sb[$];
  program_counter_if #(.WIDTH(16)) bus ();
  program_counter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    obs = {bus.out, bus.wrap};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: out=%h wrap=%b, expected out=%h wrap=%b", tag, obs[16:1], obs[0], exp[16:1], exp[0]);
    end
  endtask
  task automatic step(input string tag, input logic c, input logic l, input logic i, input logic d, input logic [15:0] v);
    bus.clr = c; bus.load = l; bus.inc = i; bus.dec = d; bus.in = v;
    if (c) begin m_out = 16'h0; m_wrap = 1'b0; end
    else if (l) begin m_out = v; m_wrap = 1'b0; end
    else if (i && !d) begin m_wrap = (m_out == 16'hFFFF); m_out = m_out + 16'h1; end
    else if (d && !i) begin m_wrap = (m_out == 16'h0000); m_out = m_out - 16'h1; end
    else m_wrap = 1'b0;
    sb.push_back({m_out, m_wrap});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, out=%h", tag, bus.out);
    end else check(tag, sb.pop_front());
  endtask
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    m_out = 16'h0; m_wrap = 1'b0;
    #1 check({tag, "_async"}, 17'h0);
    bus.clr = $urandom_range(1); bus.load = $urandom_range(1); bus.inc = 1'b1; bus.dec = $urandom_range(1); bus.in = 16'($urandom);
    @(posedge clk);
    #1 check({tag, "_hold"}, 17'h0);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    bus.clr = 'x; bus.load = 'x; bus.inc = 'x; bus.dec = 'x; bus.in = 'x;
    #3 check("reset_x_ctrl", 17'h0);
    @(posedge clk);
    #1 check("reset_hold_x", 17'h0);
    bus.clr = 0; bus.load = 0; bus.inc = 0; bus.dec = 0; bus.in = 0;
    #2 rst_n = 1'b1;
    step("load0", 0, 1, 0, 0, 16'h0000);
    for (int k = 0; k < 5; k++) step("inc_to5", 0, 0, 1, 0, 16'h0);
    pulse_reset("rst_mid");
    step("inc_after_rst", 0, 0, 1, 0, 16'h0);
    step("load1234", 0, 1, 0, 0, 16'h1234);
    for (int k = 0; k < 3; k++) step("inc_1235", 0, 0, 1, 0, 16'h0);
    step("loadFFFE", 0, 1, 0, 0, 16'hFFFE);
    step("incFFFF", 0, 0, 1, 0, 16'h0);
    step("inc_wrap", 0, 0, 1, 0, 16'h0);
    step("idle_clrwrap", 0, 0, 0, 0, 16'h0);
    step("dec_wrap", 0, 0, 0, 1, 16'h0);
    step("decFFFE", 0, 0, 0, 1, 16'h0);
    step("load0010", 0, 1, 0, 0, 16'h0010);
    step("clr_wins", 1, 1, 1, 0, 16'hAAAA);
    step("load_wins", 0, 1, 1, 0, 16'hAAAA);
    step("incdec_hold", 0, 0, 1, 1, 16'h5555);
    step("clr_dec", 1, 0, 0, 1, 16'h0);
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(199) == 0) pulse_reset("rnd_rst");
      else step("random", $urandom_range(15) == 0, $urandom_range(7) == 0, 1'($urandom), 1'($urandom),
                $urandom_range(3) == 0 ? 16'hFFFF : 16'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
